// File: rtl/tagged_hybrid_predictor.sv
// -----------------------------------------------------------------------------
// tagged_hybrid_predictor
//
// Branch direction predictor (bimodal, gshare or chooser-selected hybrid) with
// a tagged, valid-qualified BTB. All tables are cleared by a post-reset init
// sequencer that walks one entry per cycle. The GHR value used for each
// prediction is exported so the resolving stage can hand it back and update
// exactly the entries that produced the prediction.
//
// Parameters
//   INDEX_BITS : log2 of table depth (PHT, bimodal, chooser, BTB)
//   HIST_BITS  : global history length, 1 <= HIST_BITS <= INDEX_BITS
//   TAG_BITS   : BTB tag width, tag = pc[TAG_BITS+INDEX_BITS+1 : INDEX_BITS+2]
//   MODE       : 0 = bimodal, 1 = gshare, 2 = hybrid
//
// Ports
//   clk            : clock, all state on posedge
//   reset          : synchronous, active-high
//   pc_in          : fetch PC to predict
//   pred_taken     : predicted taken (direction taken and BTB hit)
//   pred_target    : BTB target when pred_taken, else pc_in + 4
//   pred_hist      : GHR snapshot used for this prediction
//   update_valid   : resolved branch present this cycle
//   branch_pc      : PC of the resolved branch
//   taken          : actual outcome
//   actual_target  : actual taken target
//   upd_hist       : pred_hist carried with the branch
//   upd_pred_taken : pred_taken carried with the branch
//   init_busy      : table init in progress
//   mispredict_cnt : number of updates where upd_pred_taken != taken
// -----------------------------------------------------------------------------
module tagged_hybrid_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int HIST_BITS  = 6,
    parameter int TAG_BITS   = 8,
    parameter int MODE       = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          pc_in,
    output logic                 pred_taken,
    output logic [31:0]          pred_target,
    output logic [HIST_BITS-1:0] pred_hist,
    input  logic                 update_valid,
    input  logic [31:0]          branch_pc,
    input  logic                 taken,
    input  logic [31:0]          actual_target,
    input  logic [HIST_BITS-1:0] upd_hist,
    input  logic                 upd_pred_taken,
    output logic                 init_busy,
    output logic [31:0]          mispredict_cnt
);

    localparam int DEPTH   = 2 ** INDEX_BITS;
    localparam int TAG_LSB = INDEX_BITS + 2;
    localparam int TAG_MSB = TAG_BITS + INDEX_BITS + 1;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                  state;
    logic [INDEX_BITS-1:0]   ptr;
    logic [HIST_BITS-1:0]    ghr;

    logic [1:0]              pht        [DEPTH];
    logic [1:0]              bim        [DEPTH];
    logic [1:0]              cho        [DEPTH];
    logic                    btb_valid  [DEPTH];
    logic [TAG_BITS-1:0]     btb_tag    [DEPTH];
    logic [31:0]             btb_target [DEPTH];

    function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic up);
        logic [1:0] nxt;
        if (up) nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        else    nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        return nxt;
    endfunction

    // ------------------------------------------------------------------
    // Prediction (combinational, zero latency)
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0] idx;
    logic [INDEX_BITS-1:0] gidx;
    logic [TAG_BITS-1:0]   ptag;
    logic                  dir_bim;
    logic                  dir_gsh;
    logic                  dir;
    logic                  hit;

    assign idx     = pc_in[INDEX_BITS+1:2];
    assign gidx    = idx ^ INDEX_BITS'(ghr);
    assign ptag    = pc_in[TAG_MSB:TAG_LSB];
    assign dir_bim = bim[idx][1];
    assign dir_gsh = pht[gidx][1];

    always_comb begin
        dir = dir_bim;
        if (MODE == 1)      dir = dir_gsh;
        else if (MODE == 2) dir = cho[idx][1] ? dir_gsh : dir_bim;
    end

    assign hit         = btb_valid[idx] && (btb_tag[idx] == ptag);
    assign pred_taken  = (state == ST_READY) && dir && hit;
    assign pred_target = pred_taken ? btb_target[idx] : pc_in + 32'd4;
    assign pred_hist   = ghr;

    // ------------------------------------------------------------------
    // Update-side decode
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0] bidx;
    logic [INDEX_BITS-1:0] ugidx;
    logic [TAG_BITS-1:0]   btag;
    logic                  do_update;
    logic                  gsh_ok;
    logic                  bim_ok;
    logic [HIST_BITS-1:0]  next_ghr;
    logic                  unused_bits;

    assign bidx      = branch_pc[INDEX_BITS+1:2];
    assign ugidx     = bidx ^ INDEX_BITS'(upd_hist);
    assign btag      = branch_pc[TAG_MSB:TAG_LSB];
    assign do_update = (state == ST_READY) && update_valid && !reset;

    // Chooser training looks at the counters as they were before this update.
    assign gsh_ok = (pht[ugidx][1] == taken);
    assign bim_ok = (bim[bidx][1] == taken);

    // History is rebuilt from the snapshot carried with the branch, which
    // repairs any speculative drift in the fetch-side view.
    generate
        if (HIST_BITS == 1) begin : g_hist1
            assign next_ghr = taken;
        end else begin : g_histn
            assign next_ghr = {upd_hist[HIST_BITS-2:0], taken};
        end
    endgenerate

    assign unused_bits = ^{branch_pc[1:0], branch_pc[31:TAG_MSB+1]};

    // ------------------------------------------------------------------
    // Control FSM: init sequencer, history and mispredict counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_INIT;
            ptr            <= '0;
            init_busy      <= 1'b1;
            ghr            <= '0;
            mispredict_cnt <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    ptr <= ptr + INDEX_BITS'(1);
                    if (&ptr) begin
                        state     <= ST_READY;
                        init_busy <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (update_valid) begin
                        ghr            <= next_ghr;
                        mispredict_cnt <= mispredict_cnt + {31'd0, upd_pred_taken != taken};
                    end
                end
                default: begin
                    state     <= ST_INIT;
                    ptr       <= '0;
                    init_busy <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Tables: cleared entry-by-entry during INIT, trained when READY.
    // Tables the selected MODE never reads are left alone.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset && state == ST_INIT) begin
            pht[ptr]       <= 2'b01;
            bim[ptr]       <= 2'b01;
            cho[ptr]       <= 2'b01;
            btb_valid[ptr] <= 1'b0;
        end else if (do_update) begin
            if (MODE != 1) bim[bidx] <= sat_step(bim[bidx], taken);
            if (MODE != 0) pht[ugidx] <= sat_step(pht[ugidx], taken);
            if (MODE == 2) begin
                if (gsh_ok && !bim_ok)      cho[bidx] <= sat_step(cho[bidx], 1'b1);
                else if (!gsh_ok && bim_ok) cho[bidx] <= sat_step(cho[bidx], 1'b0);
            end
            if (taken) begin
                btb_valid[bidx]  <= 1'b1;
                btb_tag[bidx]    <= btag;
                btb_target[bidx] <= actual_target;
            end
        end
    end

endmodule

// File: tb/tb_tagged_hybrid_predictor.sv
module tb_tagged_hybrid_predictor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_in = '0;
    logic        update_valid = 1'b0;
    logic [31:0] branch_pc = '0;
    logic        taken = 1'b0;
    logic [31:0] actual_target = '0;
    logic [5:0]  upd_hist = '0;
    logic        upd_pred_taken = 1'b0;

    logic [2:0]  pt;
    logic [31:0] ptgt [3];
    logic [5:0]  ph   [3];
    logic [2:0]  busy;
    logic [31:0] cnt  [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tagged_hybrid_predictor #(.INDEX_BITS(6), .HIST_BITS(6), .TAG_BITS(8), .MODE(0)) u_bim (
        .clk(clk), .reset(reset), .pc_in(pc_in),
        .pred_taken(pt[0]), .pred_target(ptgt[0]), .pred_hist(ph[0]),
        .update_valid(update_valid), .branch_pc(branch_pc), .taken(taken),
        .actual_target(actual_target), .upd_hist(upd_hist), .upd_pred_taken(upd_pred_taken),
        .init_busy(busy[0]), .mispredict_cnt(cnt[0]));

    tagged_hybrid_predictor #(.INDEX_BITS(6), .HIST_BITS(6), .TAG_BITS(8), .MODE(1)) u_gsh (
        .clk(clk), .reset(reset), .pc_in(pc_in),
        .pred_taken(pt[1]), .pred_target(ptgt[1]), .pred_hist(ph[1]),
        .update_valid(update_valid), .branch_pc(branch_pc), .taken(taken),
        .actual_target(actual_target), .upd_hist(upd_hist), .upd_pred_taken(upd_pred_taken),
        .init_busy(busy[1]), .mispredict_cnt(cnt[1]));

    tagged_hybrid_predictor #(.INDEX_BITS(6), .HIST_BITS(6), .TAG_BITS(8), .MODE(2)) u_hyb (
        .clk(clk), .reset(reset), .pc_in(pc_in),
        .pred_taken(pt[2]), .pred_target(ptgt[2]), .pred_hist(ph[2]),
        .update_valid(update_valid), .branch_pc(branch_pc), .taken(taken),
        .actual_target(actual_target), .upd_hist(upd_hist), .upd_pred_taken(upd_pred_taken),
        .init_busy(busy[2]), .mispredict_cnt(cnt[2]));

    // ---------------- reference model (spec-level) ----------------
    int          m_bim [64];
    int          m_pht [64];
    int          m_cho [64];
    bit          m_bv  [64];
    int          m_tag [64];
    logic [31:0] m_tgt [64];
    int          m_ghr;
    logic [31:0] m_cnt;
    int          m_busy_left;

    bit          obs_pt  [3];
    logic [31:0] obs_tgt [3];
    logic [5:0]  obs_ph  [3];

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) & 32'd63);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc >> 8) & 32'd255);
    endfunction

    function automatic int sat(input int c, input bit up);
        if (up) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    function automatic bit model_taken(input int mode, input logic [31:0] pc);
        int i = idx_of(pc);
        int g = i ^ m_ghr;
        bit d;
        if (mode == 0)      d = (m_bim[i] >= 2);
        else if (mode == 1) d = (m_pht[g] >= 2);
        else                d = (m_cho[i] >= 2) ? (m_pht[g] >= 2) : (m_bim[i] >= 2);
        return (m_busy_left == 0) && d && m_bv[i] && (m_tag[i] == tag_of(pc));
    endfunction

    function automatic void model_clock();
        if (reset) begin
            m_ghr = 0;
            m_cnt = 0;
            m_busy_left = 64;
            for (int i = 0; i < 64; i++) begin
                m_bim[i] = 1; m_pht[i] = 1; m_cho[i] = 1; m_bv[i] = 0;
            end
        end else if (m_busy_left > 0) begin
            m_busy_left--;
        end else if (update_valid) begin
            int b  = idx_of(branch_pc);
            int ug = b ^ int'(upd_hist);
            bit gs_ok = ((m_pht[ug] >= 2) == taken);
            bit bm_ok = ((m_bim[b] >= 2) == taken);
            if (gs_ok && !bm_ok)      m_cho[b] = sat(m_cho[b], 1'b1);
            else if (!gs_ok && bm_ok) m_cho[b] = sat(m_cho[b], 1'b0);
            m_pht[ug] = sat(m_pht[ug], taken);
            m_bim[b]  = sat(m_bim[b], taken);
            m_ghr = ((int'(upd_hist) << 1) | int'(taken)) & 63;
            if (taken) begin
                m_bv[b]  = 1'b1;
                m_tag[b] = tag_of(branch_pc);
                m_tgt[b] = actual_target;
            end
            if (upd_pred_taken != taken) m_cnt = m_cnt + 32'd1;
        end
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, compare against model, then advance model.
    task automatic cyc(input bit rst, input logic [31:0] pc, input bit uv, input logic [31:0] bpc,
                       input bit tk, input logic [31:0] tgt, input logic [5:0] uh, input bit upt);
        bit          et;
        logic [31:0] etgt;
        @(negedge clk);
        reset = rst; pc_in = pc; update_valid = uv; branch_pc = bpc;
        taken = tk; actual_target = tgt; upd_hist = uh; upd_pred_taken = upt;
        #1;
        for (int m = 0; m < 3; m++) begin
            obs_pt[m] = pt[m]; obs_tgt[m] = ptgt[m]; obs_ph[m] = ph[m];
            et   = model_taken(m, pc);
            etgt = et ? m_tgt[idx_of(pc)] : pc + 32'd4;
            check_val($sformatf("pred_taken_m%0d", m), {31'd0, pt[m]}, {31'd0, et});
            check_val($sformatf("pred_target_m%0d", m), ptgt[m], etgt);
            check_val($sformatf("pred_hist_m%0d", m), {26'd0, ph[m]}, 32'(m_ghr));
            check_val($sformatf("init_busy_m%0d", m), {31'd0, busy[m]}, {31'd0, m_busy_left > 0});
        end
        check_val("mispredict_cnt", cnt[2], m_cnt);
        @(posedge clk);
        model_clock();
    endtask

    task automatic idle(input logic [31:0] pc);
        cyc(1'b0, pc, 1'b0, 32'd0, 1'b0, 32'd0, 6'd0, 1'b0);
    endtask

    task automatic init_run(input string tag);
        for (int i = 0; i < 65; i++) begin
            idle(32'h40);
            check_val($sformatf("%s_busy_%0d", tag, i), {31'd0, busy[2]}, {31'd0, i < 64});
            if (i < 64) check_val($sformatf("%s_nopred_%0d", tag, i), {29'd0, pt}, 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rpc, rbpc;
        logic [5:0]  hp;
        bit          pp, tk;

        // power-up: hold reset for two edges, then release and watch init
        @(posedge clk); @(posedge clk);
        model_clock();
        init_run("t1");

        // bimodal: single taken update trains counter and BTB
        cyc(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h20, 6'd0, 1'b0);
        idle(32'h40);
        check_val("t2_taken", {31'd0, obs_pt[0]}, 32'd1);
        check_val("t2_target", obs_tgt[0], 32'h20);
        check_val("t2_cnt", cnt[0], 32'd1);

        // alias with different tag must miss
        idle(32'h4040);
        check_val("t3_taken", {31'd0, obs_pt[0]}, 32'd0);
        check_val("t3_target", obs_tgt[0], 32'h4044);

        // same-cycle predict/update: old state now, decremented state next cycle
        cyc(1'b0, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 6'd0, 1'b1);
        check_val("t5_old_taken", {31'd0, obs_pt[0]}, 32'd1);
        check_val("t5_old_target", obs_tgt[0], 32'h20);
        idle(32'h40);
        check_val("t5_new_taken", {31'd0, obs_pt[0]}, 32'd0);
        check_val("t5_new_target", obs_tgt[0], 32'h44);
        check_val("t5_cnt", cnt[0], 32'd2);

        // gshare learns an alternating branch when history is carried along
        for (int i = 0; i < 16; i++) begin
            idle(32'h80);
            hp = obs_ph[1];
            pp = obs_pt[1];
            tk = (i % 2 == 0);
            if (i >= 12) check_val($sformatf("t4_pred_%0d", i), {31'd0, pp}, {31'd0, tk});
            cyc(1'b0, 32'h80, 1'b1, 32'h80, tk, 32'h100, hp, pp);
        end

        // reset partway through init restarts the walk and clears trained entries
        cyc(1'b1, 32'h80, 1'b0, 32'd0, 1'b0, 32'd0, 6'd0, 1'b0);
        for (int i = 0; i <= 30; i++) idle(32'h80);
        cyc(1'b1, 32'h80, 1'b0, 32'd0, 1'b0, 32'd0, 6'd0, 1'b0);
        init_run("t6");
        idle(32'h80);
        check_val("t6_cleared_m1", {31'd0, obs_pt[1]}, 32'd0);
        check_val("t6_cleared_m2", {31'd0, obs_pt[2]}, 32'd0);
        check_val("t6_cleared_target", obs_tgt[0], 32'h84);
        check_val("t6_cnt", cnt[1], 32'd0);

        // randomized traffic over a small set of indices and two tags
        for (int n = 0; n < 500; n++) begin
            rpc  = ($urandom_range(0, 1) << 8) | ($urandom_range(0, 7) << 2) | ($urandom_range(0, 1) << 20);
            rbpc = ($urandom_range(0, 1) << 8) | ($urandom_range(0, 7) << 2);
            hp   = ($urandom_range(0, 1) == 0) ? 6'(m_ghr) : 6'($urandom_range(0, 63));
            cyc(1'b0, rpc, $urandom_range(0, 9) < 7, rbpc, 1'($urandom_range(0, 1)),
                $urandom & 32'hFFFF_FFFC, hp, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
